// File: rtl/rmii_rx_if.sv
// ---------------------------------------------------------------------------
// rmii_rx_if -- signal bundle between an RMII PHY receive path and the
// byte-level receiver.
//
// PHY -> receiver:
//   crs_dv     carrier sense / receive data valid
//   rx_data    receive dibit (2 bits per 50 MHz cycle)
//   rx_err     PHY receive error
// Receiver -> client:
//   rx_byte    assembled byte, valid only while rx_valid=1
//   rx_valid   one-cycle strobe per byte
//   rx_sof     qualifies rx_valid on the first byte of a frame
//   frame_done one-cycle end-of-frame strobe
//   frame_ok   frame status, meaningful only with frame_done
//   frame_len  bytes emitted for the frame, meaningful only with frame_done
//
// Modports:
//   master  the PHY/client side (drives the RMII inputs, observes results)
//   slave   the receiver (rmii_rx)
// ---------------------------------------------------------------------------
interface rmii_rx_if;
    logic        crs_dv;
    logic [1:0]  rx_data;
    logic        rx_err;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_sof;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;

    modport master (
        output crs_dv,
        output rx_data,
        output rx_err,
        input  rx_byte,
        input  rx_valid,
        input  rx_sof,
        input  frame_done,
        input  frame_ok,
        input  frame_len
    );

    modport slave (
        input  crs_dv,
        input  rx_data,
        input  rx_err,
        output rx_byte,
        output rx_valid,
        output rx_sof,
        output frame_done,
        output frame_ok,
        output frame_len
    );
endinterface

// File: rtl/rmii_rx.sv
// ---------------------------------------------------------------------------
// rmii_rx -- RMII 100 Mb/s receive deframer.
//
// Samples one dibit per rising clk edge, hunts for the preamble (01...) and
// SFD tail (11), then assembles bytes LSB dibit first and emits them as
// one-cycle strobes. At end of carrier it reports frame length and status.
// Frames longer than MAX_LEN are cut at MAX_LEN bytes and reported bad; the
// rest of their carrier is swallowed silently.
//
// Parameters:
//   MIN_LEN   minimum good frame length in bytes (after SFD)
//   MAX_LEN   maximum good frame length in bytes, 1..2047
//
// Ports:
//   clk       50 MHz RMII reference clock, rising edge
//   rst       asynchronous active-high reset
//   rx_if     rmii_rx_if.slave bundle (RMII inputs, byte/frame outputs)
//
// All outputs are registered. Inputs are used directly: RMII data is
// synchronous to the reference clock, so no synchronisers are inserted.
// ---------------------------------------------------------------------------
module rmii_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic      clk,
    input  logic      rst,
    rmii_rx_if.slave  rx_if
);

    // State encoding
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam logic [1:0] S_DATA     = 2'd2;
    localparam logic [1:0] S_DROP     = 2'd3;

    // Line symbols of interest
    localparam logic [1:0] DIB_PRE = 2'b01;
    localparam logic [1:0] DIB_SFD = 2'b11;

    localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

    // Control state
    logic [1:0]  r_state;
    logic [1:0]  r_idx;     // dibit position inside the current byte
    logic [10:0] r_cnt;     // bytes emitted so far in this frame
    logic        r_err;     // sticky PHY error seen during DATA
    logic [5:0]  r_shift;   // first three dibits of the byte in progress

    // Output registers
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_rx_sof;
    logic        r_frame_done;
    logic        r_frame_ok;
    logic [10:0] r_frame_len;

    // Input aliases
    logic        w_crs;
    logic [1:0]  w_dib;
    logic        w_err;

    assign w_crs = rx_if.crs_dv;
    assign w_dib = rx_if.rx_data;
    assign w_err = rx_if.rx_err;

    assign rx_if.rx_byte    = r_rx_byte;
    assign rx_if.rx_valid   = r_rx_valid;
    assign rx_if.rx_sof     = r_rx_sof;
    assign rx_if.frame_done = r_frame_done;
    assign rx_if.frame_ok   = r_frame_ok;
    assign rx_if.frame_len  = r_frame_len;

    // Place a dibit into the partial byte at the given position. Position 3
    // never lands here: the fourth dibit goes straight into the output byte.
    function automatic logic [5:0] insert_dibit(
        input logic [5:0] acc,
        input logic [1:0] idx,
        input logic [1:0] dib
    );
        logic [5:0] res;
        res = acc;
        case (idx)
            2'd0:    res[1:0] = dib;
            2'd1:    res[3:2] = dib;
            2'd2:    res[5:4] = dib;
            default: res      = acc;
        endcase
        return res;
    endfunction

    // Completed byte: first dibit is the least significant pair.
    function automatic logic [7:0] assemble_byte(
        input logic [5:0] low,
        input logic [1:0] top
    );
        return {top, low};
    endfunction

    // Good frame: no PHY error, ended on a byte boundary, length in range.
    function automatic logic frame_good(
        input logic        err,
        input logic [1:0]  idx,
        input logic [10:0] cnt
    );
        return !err && (idx == 2'd0) && (cnt >= LEN_MIN) && (cnt <= LEN_MAX);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= 11'd0;
            r_err        <= 1'b0;
            r_shift      <= 6'd0;
            r_rx_byte    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_len  <= 11'd0;
        end else begin
            // Strobes are single-cycle by default
            r_rx_valid   <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_crs && (w_dib == DIB_PRE)) begin
                        r_state <= S_PREAMBLE;
                    end
                end

                S_PREAMBLE: begin
                    if (!w_crs) begin
                        r_state <= S_IDLE;
                    end else if (w_err) begin
                        r_state <= S_DROP;
                    end else if (w_dib == DIB_PRE) begin
                        r_state <= S_PREAMBLE;
                    end else if (w_dib == DIB_SFD) begin
                        r_state <= S_DATA;
                        r_idx   <= 2'd0;
                        r_cnt   <= 11'd0;
                        r_err   <= 1'b0;
                    end else begin
                        // 00 or 10 inside the preamble: not a frame we trust
                        r_state <= S_DROP;
                    end
                end

                S_DATA: begin
                    if (!w_crs) begin
                        // End of carrier: any partial byte is discarded but
                        // still marks the frame bad via the index check.
                        r_frame_done <= 1'b1;
                        r_frame_len  <= r_cnt;
                        r_frame_ok   <= frame_good(r_err, r_idx, r_cnt);
                        r_idx        <= 2'd0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_shift <= insert_dibit(r_shift, r_idx, w_dib);
                        r_idx   <= r_idx + 2'd1;
                        if (w_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_idx == 2'd3) begin
                            if (r_cnt == LEN_MAX) begin
                                // Oversize: close the frame now, eat the rest
                                r_frame_done <= 1'b1;
                                r_frame_ok   <= 1'b0;
                                r_frame_len  <= LEN_MAX;
                                r_state      <= S_DROP;
                            end else begin
                                r_rx_valid <= 1'b1;
                                r_rx_byte  <= assemble_byte(r_shift, w_dib);
                                r_rx_sof   <= (r_cnt == 11'd0);
                                r_cnt      <= r_cnt + 11'd1;
                            end
                        end
                    end
                end

                S_DROP: begin
                    if (!w_crs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx.sv
// ---------------------------------------------------------------------------
// tb_rmii_rx -- directed bench for rmii_rx (MAX_LEN overridden to 100 so the
// oversize path is reachable with short frames). Expected bytes and frame
// results are queued as each frame is driven and popped as the receiver
// produces them.
// ---------------------------------------------------------------------------
module tb_rmii_rx;

    localparam int TB_MIN = 64;
    localparam int TB_MAX = 100;

    typedef struct {
        bit          is_done;
        logic [7:0]  data;
        logic        sof;
        logic        ok;
        logic [10:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    rmii_rx_if u_if ();

    rmii_rx #(
        .MIN_LEN (TB_MIN),
        .MAX_LEN (TB_MAX)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare whatever the DUT produced on the edge just passed.
    task automatic monitor();
        exp_t e;
        if (u_if.rx_valid || u_if.frame_done) begin
            check("valid_and_done_exclusive",
                  32'(u_if.rx_valid & u_if.frame_done), 32'd0);
        end
        if (u_if.rx_sof && !u_if.rx_valid) begin
            check("sof_without_valid", 32'(u_if.rx_sof), 32'd0);
        end
        if (u_if.rx_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rx_valid", 32'(u_if.rx_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("byte_expected_not_done", 32'(u_if.rx_valid), 32'(!e.is_done));
                check("rx_byte", 32'(u_if.rx_byte), 32'(e.data));
                check("rx_sof",  32'(u_if.rx_sof),  32'(e.sof));
            end
        end else if (u_if.frame_done) begin
            if (sb.size() == 0) begin
                check("spurious_frame_done", 32'(u_if.frame_done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_expected_not_byte", 32'(u_if.frame_done), 32'(e.is_done));
                check("frame_ok",  32'(u_if.frame_ok),  32'(e.ok));
                check("frame_len", 32'(u_if.frame_len), 32'(e.len));
            end
        end
    endtask

    // Drive one dibit from a falling edge, then check after the next falling edge.
    task automatic drive(input logic crs, input logic [1:0] d, input logic err);
        u_if.crs_dv  = crs;
        u_if.rx_data = d;
        u_if.rx_err  = err;
        @(negedge clk);
        monitor();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_byte"},    32'(u_if.rx_byte),    32'd0);
        check({tag, "_rx_valid"},   32'(u_if.rx_valid),   32'd0);
        check({tag, "_rx_sof"},     32'(u_if.rx_sof),     32'd0);
        check({tag, "_frame_done"}, 32'(u_if.frame_done), 32'd0);
        check({tag, "_frame_ok"},   32'(u_if.frame_ok),   32'd0);
        check({tag, "_frame_len"},  32'(u_if.frame_len),  32'd0);
    endtask

    task automatic push_byte(input int i);
        exp_t e;
        e.is_done = 1'b0;
        e.data    = 8'(i);
        e.sof     = (i == 0);
        e.ok      = 1'b0;
        e.len     = 11'd0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic ok, input int len);
        exp_t e;
        e.is_done = 1'b1;
        e.data    = 8'd0;
        e.sof     = 1'b0;
        e.ok      = ok;
        e.len     = 11'(len);
        sb.push_back(e);
    endtask

    // Full frame: 31x 01, SFD 11, bytes 0,1,2.. LSB dibit first, optional
    // trailing dibits, optional one-cycle rx_err in byte err_byte, optional
    // asynchronous reset at the start of byte rst_byte (-1 disables).
    task automatic send_frame(input int n, input int extra, input int err_byte, input int rst_byte);
        logic [7:0] b;
        bit         aborted;
        bit         ok;
        aborted = 1'b0;
        for (int p = 0; p < 31; p++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == rst_byte) begin
                #2 rst = 1'b1;
                #1 check_all_zero("mid_reset");
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (i < TB_MAX) push_byte(i);
            else if (i == TB_MAX) push_done(1'b0, TB_MAX);
            b = 8'(i);
            for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2], (i == err_byte) && (k == 1));
        end
        if (!aborted) begin
            for (int x = 0; x < extra; x++) drive(1'b1, 2'b01, 1'b0);
            if (n <= TB_MAX) begin
                ok = (err_byte < 0) && (extra % 4 == 0) && (n >= TB_MIN);
                push_done(ok, n);
            end
        end
        for (int g = 0; g < 6; g++) drive(1'b0, 2'b00, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        u_if.crs_dv  = 1'b0;
        u_if.rx_data = 2'b00;
        u_if.rx_err  = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) drive(1'b0, 2'b00, 1'b0);

        // Good minimum-length frame
        send_frame(64, 0, -1, -1);
        // Runt
        send_frame(10, 0, -1, -1);
        // One byte under minimum
        send_frame(63, 0, -1, -1);
        // Trailing partial dibit
        send_frame(64, 1, -1, -1);
        // PHY error inside byte 20
        send_frame(64, 0, 20, -1);
        // Exactly MAX_LEN is still good
        send_frame(100, 0, -1, -1);
        // Oversize: cut at MAX_LEN, rest of carrier silent
        send_frame(120, 0, -1, -1);

        // Bad preamble held on the line, then a good frame
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        for (int c = 0; c < 100; c++) drive(1'b1, 2'b10, 1'b0);
        for (int g = 0; g < 4; g++) drive(1'b0, 2'b00, 1'b0);
        check("bad_preamble_silent", 32'(sb.size()), 32'd0);
        send_frame(64, 0, -1, -1);

        // PHY error during preamble aborts without frame_done
        for (int p = 0; p < 10; p++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b1);
        for (int c = 0; c < 20; c++) drive(1'b1, 2'b11, 1'b0);
        for (int g = 0; g < 4; g++) drive(1'b0, 2'b00, 1'b0);
        check("preamble_err_silent", 32'(sb.size()), 32'd0);

        // Asynchronous reset at byte 30, then a good frame
        send_frame(64, 0, -1, 30);
        send_frame(64, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
